// File: rtl/seq_multiplier_param.sv
// Iterative shift-add multiplier, WIDTH-bit operands, per-operation signed/unsigned mode.
// start/busy/done handshake; product register holds its value until the next completion.
module seq_multiplier_param #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand_in,
  input  logic [WIDTH-1:0]     multiplier_in,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       sum;
  logic                 last_iter;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_iter) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: magnitudes are taken at capture so the loop is always unsigned;
  // the most-negative operand maps to 2^(WIDTH-1), which still fits in WIDTH bits.
  always_comb begin
    a_mag = (signed_mode && multiplicand_in[WIDTH-1]) ? (~multiplicand_in + WIDTH'(1))
                                                      : multiplicand_in;
    b_mag = (signed_mode && multiplier_in[WIDTH-1])   ? (~multiplier_in + WIDTH'(1))
                                                      : multiplier_in;
    sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mcand_q : {WIDTH{1'b0}})};

    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    product_d = product_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = a_mag;
          acc_d   = {{WIDTH{1'b0}}, b_mag};
          neg_d   = signed_mode & (multiplicand_in[WIDTH-1] ^ multiplier_in[WIDTH-1]);
          cnt_d   = '0;
        end
      end
      RUN: begin
        acc_d = {sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
      end
      FIX: begin
        product_d = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
        done_d    = 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    busy      = (state_q == RUN) || (state_q == FIX);
    done      = done_q;
    product   = product_q;
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_seq_multiplier_param.sv
// Directed bench for seq_multiplier_param: WIDTH=8 main instance plus WIDTH=4 and WIDTH=16.
module tb_seq_multiplier_param;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  // WIDTH=8 instance
  logic        start8 = 0, sm8 = 0, busy8, done8;
  logic [7:0]  a8 = 0, b8 = 0;
  logic [15:0] prod8;
  logic [1:0]  st8;
  // WIDTH=4 instance
  logic        start4 = 0, sm4 = 0, busy4, done4;
  logic [3:0]  a4 = 0, b4 = 0;
  logic [7:0]  prod4;
  logic [1:0]  st4;
  // WIDTH=16 instance
  logic        start16 = 0, sm16 = 0, busy16, done16;
  logic [15:0] a16 = 0, b16 = 0;
  logic [31:0] prod16;
  logic [1:0]  st16;

  seq_multiplier_param #(.WIDTH(8)) u8 (
    .clock(clock), .reset(reset), .start(start8), .signed_mode(sm8),
    .multiplicand_in(a8), .multiplier_in(b8), .busy(busy8), .done(done8),
    .product(prod8), .state_dbg(st8));

  seq_multiplier_param #(.WIDTH(4)) u4 (
    .clock(clock), .reset(reset), .start(start4), .signed_mode(sm4),
    .multiplicand_in(a4), .multiplier_in(b4), .busy(busy4), .done(done4),
    .product(prod4), .state_dbg(st4));

  seq_multiplier_param #(.WIDTH(16)) u16 (
    .clock(clock), .reset(reset), .start(start16), .signed_mode(sm16),
    .multiplicand_in(a16), .multiplier_in(b16), .busy(busy16), .done(done16),
    .product(prod16), .state_dbg(st16));

  // Clock / reset
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Drivers: called #1 after an edge; return edges from the capture edge to done.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                     output logic [15:0] p, output int lat, output int bcnt, output int ovl);
    a8 = a; b8 = b; sm8 = s; start8 = 1;
    step();
    start8 = 0;
    lat = 0; ovl = 0;
    bcnt = busy8 ? 1 : 0;
    while (!done8 && lat < 100) begin
      step();
      lat++;
      if (busy8) bcnt++;
      if (done8 && busy8) ovl++;
    end
    p = prod8;
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic s,
                     output logic [7:0] p, output int lat);
    a4 = a; b4 = b; sm4 = s; start4 = 1;
    step();
    start4 = 0;
    lat = 0;
    while (!done4 && lat < 100) begin
      step();
      lat++;
    end
    p = prod4;
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic s,
                      output logic [31:0] p, output int lat);
    a16 = a; b16 = b; sm16 = s; start16 = 1;
    step();
    start16 = 0;
    lat = 0;
    while (!done16 && lat < 100) begin
      step();
      lat++;
    end
    p = prod16;
  endtask

  task automatic test_reset();
    reset = 1;
    step(); step();
    reset = 0;
    total++; if ({busy8, done8} !== 2'b00) begin bad++; $display("FAIL reset_bd8 got=%b exp=00", {busy8, done8}); end
    total++; if (prod8 !== 16'h0) begin bad++; $display("FAIL reset_prod8 got=%h exp=0000", prod8); end
    total++; if (st8 !== 2'd0) begin bad++; $display("FAIL reset_state8 got=%0d exp=0", st8); end
    total++; if ({busy4, done4, prod4, st4} !== 12'h0) begin bad++; $display("FAIL reset_w4 got=%h exp=000", {busy4, done4, prod4, st4}); end
    total++; if ({busy16, done16, prod16, st16} !== 36'h0) begin bad++; $display("FAIL reset_w16 got=%h exp=0", {busy16, done16, prod16, st16}); end
  endtask

  task automatic test_unsigned();
    logic [15:0] p; int lat, bcnt, ovl;
    op8(8'hFF, 8'hFF, 1'b0, p, lat, bcnt, ovl);
    total++; if (p !== 16'hFE01) begin bad++; $display("FAIL u255x255 got=%h exp=fe01", p); end
    total++; if (lat !== 9) begin bad++; $display("FAIL u_latency got=%0d exp=9", lat); end
    total++; if (bcnt !== 9) begin bad++; $display("FAIL u_busy_cycles got=%0d exp=9", bcnt); end
    total++; if (ovl !== 0) begin bad++; $display("FAIL u_done_busy_overlap got=%0d exp=0", ovl); end
    step();
    total++; if (done8 !== 1'b0) begin bad++; $display("FAIL u_done_pulse_width got=%b exp=0", done8); end
    total++; if (prod8 !== 16'hFE01) begin bad++; $display("FAIL u_product_held got=%h exp=fe01", prod8); end
  endtask

  task automatic test_signed();
    logic [7:0]  ta[7] = '{8'h80, 8'h80, 8'hFF, 8'h80, 8'h80, 8'hFF, 8'hFF};
    logic [7:0]  tb[7] = '{8'h80, 8'h7F, 8'h01, 8'h80, 8'h80, 8'h02, 8'h02};
    logic        ts[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] te[7] = '{16'h4000, 16'hC080, 16'hFFFF, 16'h4000, 16'h4000, 16'h01FE, 16'hFFFE};
    logic [15:0] p; int lat, bcnt, ovl;
    for (int i = 0; i < 7; i++) begin
      op8(ta[i], tb[i], ts[i], p, lat, bcnt, ovl);
      total++; if (p !== te[i]) begin bad++; $display("FAIL mode_vec%0d got=%h exp=%h", i, p, te[i]); end
    end
  endtask

  task automatic test_busy_start_ignored();
    int lat = 0;
    a8 = 8'd200; b8 = 8'd3; sm8 = 0; start8 = 1;
    step();
    start8 = 0;
    while (!done8 && lat < 100) begin
      a8 = 8'hFF; b8 = 8'hFF; sm8 = 1;
      start8 = (lat == 2 || lat == 4);
      step();
      lat++;
    end
    start8 = 0;
    total++; if (prod8 !== 16'h0258) begin bad++; $display("FAIL busy_start_prod got=%h exp=0258", prod8); end
    total++; if (lat !== 9) begin bad++; $display("FAIL busy_start_latency got=%0d exp=9", lat); end
  endtask

  task automatic test_back_to_back();
    int lat = 0;
    a8 = 8'd10; b8 = 8'd20; sm8 = 0; start8 = 1;
    step();
    while (!done8 && lat < 100) begin
      step();
      lat++;
    end
    total++; if (prod8 !== 16'h00C8) begin bad++; $display("FAIL b2b_first got=%h exp=00c8", prod8); end
    a8 = 8'd7; b8 = 8'd9;
    step();
    start8 = 0;
    lat = 1;
    total++; if (busy8 !== 1'b1) begin bad++; $display("FAIL b2b_accepted got=%b exp=1", busy8); end
    while (!done8 && lat < 100) begin
      step();
      lat++;
    end
    total++; if (lat !== 10) begin bad++; $display("FAIL b2b_period got=%0d exp=10", lat); end
    total++; if (prod8 !== 16'h003F) begin bad++; $display("FAIL b2b_second got=%h exp=003f", prod8); end
  endtask

  task automatic test_reset_mid_op();
    logic [15:0] p; int lat, bcnt, ovl; int seen = 0;
    a8 = 8'd50; b8 = 8'd50; sm8 = 0; start8 = 1;
    step();
    start8 = 0;
    step(); step(); step(); step();
    reset = 1;
    step();
    reset = 0;
    total++; if ({busy8, done8} !== 2'b00) begin bad++; $display("FAIL midreset_bd got=%b exp=00", {busy8, done8}); end
    total++; if (prod8 !== 16'h0) begin bad++; $display("FAIL midreset_prod got=%h exp=0000", prod8); end
    for (int i = 0; i < 12; i++) begin
      step();
      if (done8) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL midreset_no_done got=%0d exp=0", seen); end
    op8(8'd13, 8'd11, 1'b0, p, lat, bcnt, ovl);
    total++; if (p !== 16'h008F) begin bad++; $display("FAIL midreset_restart got=%h exp=008f", p); end
  endtask

  task automatic test_sweep();
    logic [3:0]  a4t[6] = '{4'h0, 4'hF, 4'h8, 4'h8, 4'h7, 4'hF};
    logic [3:0]  b4t[6] = '{4'h7, 4'hF, 4'h8, 4'h7, 4'h7, 4'h3};
    logic        s4t[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [7:0]  e4t[6] = '{8'h00, 8'hE1, 8'h40, 8'hC8, 8'h31, 8'hFD};
    logic [15:0] a16t[6] = '{16'hFFFF, 16'h8000, 16'h8000, 16'h0000, 16'h1234, 16'hFFFF};
    logic [15:0] b16t[6] = '{16'hFFFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h0010, 16'h0002};
    logic        s16t[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] e16t[6] = '{32'hFFFE0001, 32'h40000000, 32'hC0008000, 32'h00000000, 32'h00012340, 32'hFFFFFFFE};
    logic [7:0]  p4; logic [31:0] p16; int lat;
    for (int i = 0; i < 6; i++) begin
      op4(a4t[i], b4t[i], s4t[i], p4, lat);
      total++; if (p4 !== e4t[i]) begin bad++; $display("FAIL w4_vec%0d got=%h exp=%h", i, p4, e4t[i]); end
      total++; if (lat !== 5) begin bad++; $display("FAIL w4_lat%0d got=%0d exp=5", i, lat); end
    end
    for (int i = 0; i < 6; i++) begin
      op16(a16t[i], b16t[i], s16t[i], p16, lat);
      total++; if (p16 !== e16t[i]) begin bad++; $display("FAIL w16_vec%0d got=%h exp=%h", i, p16, e16t[i]); end
      total++; if (lat !== 17) begin bad++; $display("FAIL w16_lat%0d got=%0d exp=17", i, lat); end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_busy_start_ignored();
    step();
    test_back_to_back();
    test_reset_mid_op();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
